// File: rtl/mul_tree_pkg.sv
// mul_tree_pkg: widths, operand/product types and the helpers that size the
// carry-save reduction tree.
package mul_tree_pkg;

  localparam int MUL_W  = 58;
  localparam int PROD_W = 2 * MUL_W;

  typedef logic [MUL_W-1:0]  operand_t;
  typedef logic [PROD_W-1:0] product_t;

  // Rows left after one level of 3:2 compression: each full group of three
  // becomes two, and leftover rows pass straight through.
  function automatic int rows_after(input int r);
    return 2 * (r / 3) + (r % 3);
  endfunction

  // Row count entering reduction level lvl, starting from n partial products.
  function automatic int rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int k = 0; k < lvl; k++) r = rows_after(r);
    return r;
  endfunction

  // Number of levels needed to bring n rows down to a sum/carry pair.
  function automatic int num_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = rows_after(r);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/mul_tree_csa_3to2.sv
// csa_3to2: bitwise full-adder array. Three rows in, a sum row and a carry
// row (already shifted into weight position) out. The carry out of the top
// bit is dropped; in this tree it is always zero.
module csa_3to2 #(
  parameter int W = 116
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  // Majority only needed on the low W-1 bits, the top one would shift out.
  always_comb begin
    sum   = x ^ y ^ z;
    carry = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};
  end

endmodule

// File: rtl/mul_tree.sv
// mul_tree: unsigned N x N -> 2N multiplier. Radix-2 AND-array partial
// products, Wallace-style 3:2 reduction to sum/carry, then one '+' CPA.
// Build option MULTREE_PIPE_EN: registers sum/carry after the tree so the
// CPA gets its own cycle (latency 2); otherwise latency is 1.
module mul_tree
  import mul_tree_pkg::*;
#(
  parameter int N = MUL_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  output logic [2*N-1:0] out
);

  localparam int P      = 2 * N;
  localparam int LEVELS = num_levels(N);

  // lv[l][r] is row r entering reduction level l; rows past the live count
  // of a level are tied off to zero.
  logic [P-1:0] lv [LEVELS+1][N];

  // Partial products: row i is a gated by b[i], shifted to weight i.
  for (genvar i = 0; i < N; i++) begin : g_pp
    assign lv[0][i] = {{N{1'b0}}, a & {N{b[i]}}} << i;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int R   = rows_at(N, l);
    localparam int G   = R / 3;
    localparam int REM = R % 3;
    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(.W(P)) u_csa (
        .x    (lv[l][3*g]),
        .y    (lv[l][3*g+1]),
        .z    (lv[l][3*g+2]),
        .sum  (lv[l+1][2*g]),
        .carry(lv[l+1][2*g+1])
      );
    end
    for (genvar r = 0; r < REM; r++) begin : g_pass
      assign lv[l+1][2*G+r] = lv[l][3*G+r];
    end
    for (genvar r = 2*G+REM; r < N; r++) begin : g_tie
      assign lv[l+1][r] = '0;
    end
  end

  logic [P-1:0] tree_sum;
  logic [P-1:0] tree_carry;
  assign tree_sum   = lv[LEVELS][0];
  assign tree_carry = lv[LEVELS][1];

  logic [P-1:0] cpa_sum;
  logic [P-1:0] cpa_carry;
  logic         cpa_vld;

`ifdef MULTREE_PIPE_EN
  logic [P-1:0] sum_q, sum_d;
  logic [P-1:0] carry_q, carry_d;
  logic         vld_q, vld_d;

  // Stage-1 next state: operands are only captured alongside a valid bit.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    vld_d   = in_valid;
    if (in_valid) begin
      sum_d   = tree_sum;
      carry_d = tree_carry;
    end
  end

  // Stage-1 register between tree and CPA.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      carry_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      vld_q   <= vld_d;
    end
  end

  assign cpa_sum   = sum_q;
  assign cpa_carry = carry_q;
  assign cpa_vld   = vld_q;
`else
  assign cpa_sum   = tree_sum;
  assign cpa_carry = tree_carry;
  assign cpa_vld   = in_valid;
`endif

  logic [P-1:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;

  // Final CPA; carry out of the top bit is discarded. Output holds unless valid.
  always_comb begin
    out_d       = out_q;
    out_valid_d = cpa_vld;
    if (cpa_vld) out_d = cpa_sum + cpa_carry;
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mul_tree.sv
// tb_mul_tree: directed and random checks of mul_tree against a cycle-level
// reference (a delay line of exact products).
module tb_mul_tree;

`ifdef MULTREE_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [57:0]  a;
  logic [57:0]  b;
  logic         out_valid;
  logic [115:0] out;

  mul_tree dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out      (out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_in    = 0;
  int n_out   = 0;

  // Reference: exact product delayed by L edges; output holds last valid.
  logic         hv [L];
  logic [115:0] hp [L];
  logic [115:0] exp_out;

  task automatic chk(input string tag, input logic [115:0] got, input logic [115:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic step(input logic v, input logic [57:0] ai, input logic [57:0] bi, input logic r);
    in_valid = v;
    a        = ai;
    b        = bi;
    reset    = r;
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < L; k++) begin
        hv[k] = 1'b0;
        hp[k] = '0;
      end
      exp_out = '0;
    end else begin
      for (int k = L - 1; k > 0; k--) begin
        hv[k] = hv[k-1];
        hp[k] = hp[k-1];
      end
      hv[0] = v;
      hp[0] = {58'd0, ai} * {58'd0, bi};
      if (v) n_in++;
    end
    if (hv[L-1]) exp_out = hp[L-1];
    if (out_valid) n_out++;
    chk("out_valid", {115'd0, out_valid}, {115'd0, hv[L-1]});
    chk("out", out, exp_out);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, $urandom, $urandom, 1'b0);
  endtask

  logic [57:0] ones;
  logic [57:0] ra;
  logic [57:0] rb;

  initial begin
    ones     = '1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    reset    = 1'b1;
    for (int k = 0; k < L; k++) begin
      hv[k] = 1'b0;
      hp[k] = '0;
    end
    exp_out = '0;

    step(1'b1, 58'd5, 58'd7, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    chk("reset_out", out, 116'd0);
    chk("reset_vld", {115'd0, out_valid}, 116'd0);

    // Directed cases with hand-computed constants.
    step(1'b1, 58'd12, 58'd12, 1'b0);
    idle(L - 1);
    chk("dir_12x12", out, 116'h90);
    chk("dir_12x12_vld", {115'd0, out_valid}, 116'd1);

    step(1'b1, 58'd2, 58'd1, 1'b0);
    step(1'b1, 58'd0, 58'h3FF_FFFF_FFFF_FFFF, 1'b0);
    if (L == 2) chk("dir_2x1", out, 116'd2);
    idle(L - 1);
    chk("dir_zero", out, 116'd0);
    idle(1);
    chk("hold_after_idle", out, 116'd0);
    chk("no_vld_idle", {115'd0, out_valid}, 116'd0);

    step(1'b1, 58'h2AA_AAAA_AAAA_AAAA, 58'h333_3333_3333_3333, 1'b0);
    idle(L - 1);
    chk("dir_pattern", out, 116'h2AA_AAAA_AAAA_AAAA * 116'h333_3333_3333_3333);

    step(1'b1, ones, ones, 1'b0);
    idle(L - 1);
    chk("dir_max", out, {58'h3FF_FFFF_FFFF_FFFE, 58'h1});
    idle(2);
    chk("hold_max", out, {58'h3FF_FFFF_FFFF_FFFE, 58'h1});

    // Random stream with gaps; operand-count balance checked after drain.
    n_in  = 0;
    n_out = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: ra = ones;
        1: rb = ones;
        2: ra = '0;
        default: ;
      endcase
      step($urandom_range(0, 3) != 0, ra, rb, 1'b0);
    end
    idle(L + 1);
    chk("count_in_out", 116'(n_out), 116'(n_in));

    // Reset mid-stream: three valid inputs, reset on the second.
    step(1'b1, 58'd3, 58'd9, 1'b0);
    step(1'b1, 58'd4, 58'd9, 1'b1);
    chk("rst_mid_out", out, 116'd0);
    chk("rst_mid_vld", {115'd0, out_valid}, 116'd0);
    step(1'b1, 58'd6, 58'd9, 1'b0);
    idle(L - 1);
    chk("after_rst", out, 116'd54);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
